// File: rtl/tmr1_peripheral_if.sv
// Register-file bus between the core and the TMR1 peripheral.
//   extern_peripherals_addr     : core register-file address
//   extern_peripherals_data_in  : core write data
//   extern_peripherals_wr_en    : one-clk file-register write strobe
//   extern_peripherals_data_out : read data, 8'h00 when not selected
//   tmr1_sel                    : address hits one of the TMR1 registers
// master = core side, slave = peripheral side.
interface tmr1_peripheral_if;
   localparam int unsigned ADDR_W = 9;
   localparam int unsigned DATA_W = 8;

   logic [ADDR_W-1:0] extern_peripherals_addr;
   logic [DATA_W-1:0] extern_peripherals_data_in;
   logic              extern_peripherals_wr_en;
   logic [DATA_W-1:0] extern_peripherals_data_out;
   logic              tmr1_sel;

   modport master (
      output extern_peripherals_addr,
      output extern_peripherals_data_in,
      output extern_peripherals_wr_en,
      input  extern_peripherals_data_out,
      input  tmr1_sel
   );

   modport slave (
      input  extern_peripherals_addr,
      input  extern_peripherals_data_in,
      input  extern_peripherals_wr_en,
      output extern_peripherals_data_out,
      output tmr1_sel
   );
endinterface

// File: rtl/tmr1_peripheral.sv
// TMR1 peripheral: 16-bit timer/counter {TMR1H,TMR1L} with 1/2/4/8 prescaler
// and T1CON control, mapped into the core register file.
// Ports:
//   clk           : system clock, rising edge
//   rst           : asynchronous active-low reset
//   clkout        : core clk/4 instruction-cycle signal (internal count source)
//   t1cki         : external count clock (only with TMR1_EXT_CLK_EN)
//   tmr1if_set_en : one-clk pulse on counter overflow (sets PIR1.TMR1IF)
//   bus           : register-file bus (tmr1_peripheral_if.slave)
// Build option: define TMR1_EXT_CLK_EN to count synchronized t1cki rising edges
// when TMR1CS=1; without it TMR1CS is storage only and selects no events.
module tmr1_peripheral #(
   parameter logic [8:0] TMR1L_ADDR = 9'h00E,
   parameter logic [8:0] TMR1H_ADDR = 9'h00F,
   parameter logic [8:0] T1CON_ADDR = 9'h010
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clkout,
   input  logic               t1cki,
   output logic               tmr1if_set_en,
   tmr1_peripheral_if.slave   bus
);
   localparam int unsigned DATA_W = 8;
   localparam int unsigned CNT_W  = 16;
   localparam int unsigned PS_W   = 3;
   localparam logic [DATA_W-1:0] T1CON_WMASK = 8'h37;

   logic [DATA_W-1:0] tmr1l;
   logic [DATA_W-1:0] tmr1h;
   logic [DATA_W-1:0] t1con;
   logic [PS_W-1:0]   presc;
   logic              clkout_q;

   logic sel_l_c, sel_h_c, sel_c_c;
   logic wr_l_c, wr_h_c, wr_c_c;
   logic tick_c, ext_evt_c, src_evt_c, step_c, inc_c;
   logic [PS_W-1:0] ps_mask_c;

   // Address decode and write strobes
   assign sel_l_c = (bus.extern_peripherals_addr == TMR1L_ADDR);
   assign sel_h_c = (bus.extern_peripherals_addr == TMR1H_ADDR);
   assign sel_c_c = (bus.extern_peripherals_addr == T1CON_ADDR);
   assign bus.tmr1_sel = sel_l_c | sel_h_c | sel_c_c;

   assign wr_l_c = bus.extern_peripherals_wr_en & sel_l_c;
   assign wr_h_c = bus.extern_peripherals_wr_en & sel_h_c;
   assign wr_c_c = bus.extern_peripherals_wr_en & sel_c_c;

   // Read mux, unbuffered
   always_comb begin
      bus.extern_peripherals_data_out = '0;
      if (sel_l_c)      bus.extern_peripherals_data_out = tmr1l;
      else if (sel_h_c) bus.extern_peripherals_data_out = tmr1h;
      else if (sel_c_c) bus.extern_peripherals_data_out = t1con;
   end

   // Internal tick: first clk cycle with clkout high after being low
   assign tick_c = clkout & ~clkout_q;

`ifdef TMR1_EXT_CLK_EN
   // [0],[1] synchronizer stages, [2] previous synchronized value for edge detect
   logic [2:0] t1_sync;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) t1_sync <= '0;
      else      t1_sync <= {t1_sync[1:0], t1cki};
   end

   assign ext_evt_c = t1_sync[1] & ~t1_sync[2];
`else
   logic t1cki_unused;
   assign t1cki_unused = t1cki;
   assign ext_evt_c    = 1'b0;
`endif

   assign src_evt_c = t1con[1] ? ext_evt_c : tick_c;
   assign step_c    = t1con[0] & src_evt_c;

   // T1CKPS 0..3 -> mask 000/001/011/111
   assign ps_mask_c = {t1con[5] & t1con[4], t1con[5], t1con[5] | t1con[4]};
   assign inc_c     = step_c & ((presc & ps_mask_c) == ps_mask_c);

   // Registers, prescaler and counter; a TMR1L/H write overrides any increment
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tmr1l         <= '0;
         tmr1h         <= '0;
         t1con         <= '0;
         presc         <= '0;
         clkout_q      <= 1'b0;
         tmr1if_set_en <= 1'b0;
      end else begin
         clkout_q      <= clkout;
         tmr1if_set_en <= 1'b0;
         if (wr_c_c) t1con <= bus.extern_peripherals_data_in & T1CON_WMASK;
         if (wr_l_c || wr_h_c) begin
            if (wr_l_c) tmr1l <= bus.extern_peripherals_data_in;
            if (wr_h_c) tmr1h <= bus.extern_peripherals_data_in;
            presc <= '0;
         end else if (step_c) begin
            if (inc_c) begin
               presc          <= '0;
               {tmr1h, tmr1l} <= CNT_W'({tmr1h, tmr1l} + CNT_W'(1));
               tmr1if_set_en  <= &{tmr1h, tmr1l};
            end else begin
               presc <= PS_W'(presc + PS_W'(1));
            end
         end
      end
   end
endmodule

// File: doc/tmr1_peripheral.md
TMR1_PERIPHERAL -- requirements
Module: tmr1_peripheral

Interface
REQ-001 Parameter: TMR1L_ADDR, 9'h00E, register-file address of TMR1L.
REQ-002 Parameter: TMR1H_ADDR, 9'h00F, register-file address of TMR1H.
REQ-003 Parameter: T1CON_ADDR, 9'h010, register-file address of T1CON.
REQ-004 Port: clk  in  1  the single system clock; all state changes on rising edge.
REQ-005 Port: rst  in  1  asynchronous, active-low reset.
REQ-006 Port: clkout  in  1  core clk/4 instruction-cycle signal.
REQ-007 Port: extern_peripherals_addr  in  9  core register-file address.
REQ-008 Port: extern_peripherals_data_in  in  8  core write data (ALU result).
REQ-009 Port: extern_peripherals_wr_en  in  1  core file-register write strobe, one clk wide.
REQ-010 Port: extern_peripherals_data_out  out  8  read data for the selected register; 8'h00 when not selected.
REQ-011 Port: tmr1_sel  out  1  high when the address matches any of the three registers.
REQ-012 Port: tmr1if_set_en  out  1  one-clk pulse on TMR1 overflow, used to set PIR1.TMR1IF.
REQ-013 Port: t1cki  in  1  external count clock; used only with TMR1_EXT_CLK_EN.

Function
REQ-014 T1CON bit use: [5:4] T1CKPS, [2] nT1SYNC (stored only), [1] TMR1CS, [0] TMR1ON; bits [7:6] and [3] read as 0 and ignore writes.
REQ-015 Internal tick: one clk cycle following each 0->1 transition of clkout, detected with a registered copy of clkout.
REQ-016 Count source: the internal tick when TMR1CS=0; the external edge (REQ-029) when TMR1CS=1.
REQ-017 Prescaler: 3-bit counter dividing the count source by 1, 2, 4 or 8 for T1CKPS values 0, 1, 2 or 3.
REQ-018 Prescaler output: an increment enable when (prescaler & mask)==mask on a count-source event; the prescaler wraps to 0 at that point.
REQ-019 Counter: 16 bits {TMR1H,TMR1L}; it increments by 1 on each increment enable while TMR1ON=1.
REQ-020 TMR1ON=0: counter and prescaler hold; count-source events are ignored.
REQ-021 Overflow: an increment from 16'hFFFF gives 16'h0000, and tmr1if_set_en is high for exactly the next clk cycle.
REQ-022 Write: when wr_en=1 and the address matches, the addressed register loads data_in on that clk edge.
REQ-023 A write to TMR1L or TMR1H also clears the prescaler to 0.
REQ-024 Write and increment in the same cycle: the write wins; the counter takes the written byte plus the unwritten byte unincremented; no overflow pulse.
REQ-025 A write to T1CON does not alter the counter or the prescaler.
REQ-026 Read: extern_peripherals_data_out is combinational from the address and the current register value; 16-bit reads are not buffered.
REQ-027 No handshake: the block is always ready, and writes take effect with zero wait states.

Reset
REQ-028 rst=0 asynchronously sets TMR1L=8'h00, TMR1H=8'h00, T1CON=8'h00, prescaler=0, clkout copy=0, t1cki sync flops=0 and tmr1if_set_en=0; after reset, data_out for a matching address reads 8'h00.

Configuration
REQ-029 TMR1_EXT_CLK_EN defined: t1cki passes through a 2-flop synchronizer; a 0->1 edge on the synchronized value, with TMR1CS=1, is one count-source event.
REQ-030 TMR1_EXT_CLK_EN undefined: t1cki is unused; TMR1CS is stored and read back, but with TMR1CS=1 no count-source events occur and the counter holds.

Verification
REQ-031 Reset: assert rst=0 mid-count at TMR1=16'h1234 -> all three registers read 8'h00 immediately, and tmr1if_set_en=0.
REQ-032 Prescale: T1CON=8'h31 (1:8, internal, on), TMR1=0 -> TMR1=16'h0001 after 8 ticks and 16'h0002 after 16 ticks.
REQ-033 Overflow: TMR1H=8'hFF, TMR1L=8'hFE, T1CON=8'h01 -> after 2 ticks TMR1=16'h0000, and tmr1if_set_en is high for exactly one clk.
REQ-034 Collision: write TMR1L=8'h55 on the same clk as an increment from 16'h00FF -> TMR1=16'h0055, and no pulse occurs.
REQ-035 Prescaler clear: T1CKPS=3, after 5 ticks write TMR1H=8'h10 -> the first increment occurs 8 ticks after the write.
REQ-036 External clock (TMR1_EXT_CLK_EN defined): T1CON=8'h03, 3 t1cki pulses -> TMR1=16'h0003, with each increment 3 clk after its t1cki rise; without the macro, TMR1 stays at 16'h0000.
